// File: rtl/dac_serial_multi.sv
// Serial-DAC update engine: snapshots channel words on a trigger edge and
// shifts one {address, data} frame per enabled channel with CS/SCLK/LDAC timing.
module dac_serial_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned SCLK_DIV  = 4,
  parameter int unsigned CS_SETUP  = 4,
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned LDAC_W    = 3,
  parameter int unsigned GAP       = 4,
  parameter int unsigned LDAC_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trig,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic                     busy,
  output logic                     done,
  output logic                     trig_ovr,
  output logic                     dac_cs_n,
  output logic                     dac_ldac_n,
  output logic                     dac_rs_n,
  output logic                     dac_msb,
  output logic                     dac_sclk,
  output logic                     dac_sdin
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned HALF    = SCLK_DIV / 2;
  localparam int unsigned DIV_W   = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned PTR_W   = $clog2(NUM_CH + 1);
  localparam int unsigned T_A     = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned T_B     = (LDAC_W > GAP) ? LDAC_W : GAP;
  localparam int unsigned T_MAX   = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETUP, S_SHIFT, S_HOLD, S_LDAC, S_GAP, S_DONE
  } state_t;

  state_t                   state;
  logic                     trig_s1, trig_s2;
  logic                     trig_edge;
  logic [NUM_CH-1:0]        mask_sh;
  logic [NUM_CH*DATA_W-1:0] data_sh;
  logic [FRAME_W-1:0]       frame;
  logic [PTR_W-1:0]         ptr;
  logic [DIV_W-1:0]         div_cnt;
  logic [DIV_W-1:0]         div_nxt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [TMR_W-1:0]         tmr;
  logic                     sent_any;
  logic                     from_ldac;

  logic                     sel_found;
  logic [ADDR_W-1:0]        sel_idx;
  logic [DATA_W-1:0]        sel_data;

  assign dac_msb   = 1'b1;
  assign trig_edge = trig_s1 & ~trig_s2;
  assign div_nxt   = (div_cnt == DIV_W'(SCLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);

  // Lowest enabled channel at or above the pointer; the descending scan lets the lowest win.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (mask_sh[k] && (k >= int'(ptr))) begin
        sel_found = 1'b1;
        sel_idx   = ADDR_W'(k);
        sel_data  = data_sh[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      trig_s1    <= 1'b0;
      trig_s2    <= 1'b0;
      mask_sh    <= '0;
      data_sh    <= '0;
      frame      <= '0;
      ptr        <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tmr        <= '0;
      sent_any   <= 1'b0;
      from_ldac  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_ovr   <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_ldac_n <= 1'b1;
      dac_rs_n   <= 1'b0;
      dac_sclk   <= 1'b0;
      dac_sdin   <= 1'b0;
    end else begin
      trig_s1  <= trig;
      trig_s2  <= trig_s1;
      dac_rs_n <= 1'b1;
      done     <= 1'b0;
      trig_ovr <= trig_edge && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          dac_cs_n   <= 1'b1;
          dac_sclk   <= 1'b0;
          dac_ldac_n <= 1'b1;
          if (trig_edge) begin
            mask_sh   <= ch_mask;
            data_sh   <= data_in;
            ptr       <= '0;
            sent_any  <= 1'b0;
            from_ldac <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (sel_found) begin
            frame    <= {sel_idx, sel_data};
            ptr      <= PTR_W'(sel_idx);
            dac_cs_n <= 1'b0;
            tmr      <= TMR_W'(CS_SETUP - 1);
            state    <= S_SETUP;
          end else if ((LDAC_MODE == 1) && sent_any) begin
            dac_ldac_n <= 1'b0;
            tmr        <= TMR_W'(LDAC_W - 1);
            state      <= S_LDAC;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end

        S_SETUP: begin
          if (tmr == '0) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            dac_sclk <= 1'b0;
            dac_sdin <= frame[FRAME_W-1];
            state    <= S_SHIFT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        // sclk/sdin are registered, so they are driven for the cycle indexed by div_nxt.
        S_SHIFT: begin
          div_cnt  <= div_nxt;
          dac_sclk <= (div_nxt >= DIV_W'(HALF));
          if (div_nxt == DIV_W'(HALF)) begin
            frame <= {frame[FRAME_W-2:0], 1'b0};
          end
          if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
            if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
              dac_sclk <= 1'b0;
              tmr      <= TMR_W'(CS_HOLD - 1);
              state    <= S_HOLD;
            end else begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              dac_sdin <= frame[FRAME_W-1];
            end
          end
        end

        S_HOLD: begin
          dac_sclk <= 1'b0;
          if (tmr == '0) begin
            dac_cs_n <= 1'b1;
            dac_sdin <= 1'b0;
            sent_any <= 1'b1;
            if (LDAC_MODE == 0) begin
              dac_ldac_n <= 1'b0;
              tmr        <= TMR_W'(LDAC_W - 1);
              state      <= S_LDAC;
            end else begin
              tmr   <= TMR_W'(GAP - 1);
              state <= S_GAP;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        S_LDAC: begin
          if (tmr == '0) begin
            dac_ldac_n <= 1'b1;
            from_ldac  <= 1'b1;
            tmr        <= TMR_W'(GAP - 1);
            state      <= S_GAP;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        S_GAP: begin
          dac_sdin <= 1'b0;
          if (tmr == '0) begin
            if ((LDAC_MODE == 1) && from_ldac) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              ptr   <= ptr + PTR_W'(1);
              state <= S_SELECT;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_multi.sv
// Directed bench for dac_serial_multi: default four-channel mode, single-LDAC
// mode and an eight-channel build, observed through a shared pin monitor.
module tb_dac_serial_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic        trig0 = 1'b0, trig1 = 1'b0, trig2 = 1'b0;
  logic [3:0]  mask0 = '0, mask1 = '0;
  logic [7:0]  mask2 = '0;
  logic [63:0] data0 = '0, data1 = '0;
  logic [95:0] data2 = '0;

  logic busy0, done0, ovr0, cs0, ldac0, rs0, msb0, sclk0, sdin0;
  logic busy1, done1, ovr1, cs1, ldac1, rs1, msb1, sclk1, sdin1;
  logic busy2, done2, ovr2, cs2, ldac2, rs2, msb2, sclk2, sdin2;

  dac_serial_multi u_dut0 (
    .clk(clk), .reset(rst0), .trig(trig0), .ch_mask(mask0), .data_in(data0),
    .busy(busy0), .done(done0), .trig_ovr(ovr0), .dac_cs_n(cs0), .dac_ldac_n(ldac0),
    .dac_rs_n(rs0), .dac_msb(msb0), .dac_sclk(sclk0), .dac_sdin(sdin0)
  );

  dac_serial_multi #(.LDAC_MODE(1)) u_dut1 (
    .clk(clk), .reset(rst1), .trig(trig1), .ch_mask(mask1), .data_in(data1),
    .busy(busy1), .done(done1), .trig_ovr(ovr1), .dac_cs_n(cs1), .dac_ldac_n(ldac1),
    .dac_rs_n(rs1), .dac_msb(msb1), .dac_sclk(sclk1), .dac_sdin(sdin1)
  );

  dac_serial_multi #(.NUM_CH(8), .ADDR_W(3), .DATA_W(12), .SCLK_DIV(2)) u_dut2 (
    .clk(clk), .reset(rst2), .trig(trig2), .ch_mask(mask2), .data_in(data2),
    .busy(busy2), .done(done2), .trig_ovr(ovr2), .dac_cs_n(cs2), .dac_ldac_n(ldac2),
    .dac_rs_n(rs2), .dac_msb(msb2), .dac_sclk(sclk2), .dac_sdin(sdin2)
  );

  // Pins of the instance under test, selected by sel.
  int   sel = 0;
  logic cs_m, sclk_m, sdin_m, ldac_m, done_m, busy_m, ovr_m;
  assign cs_m   = (sel == 0) ? cs0   : (sel == 1) ? cs1   : cs2;
  assign sclk_m = (sel == 0) ? sclk0 : (sel == 1) ? sclk1 : sclk2;
  assign sdin_m = (sel == 0) ? sdin0 : (sel == 1) ? sdin1 : sdin2;
  assign ldac_m = (sel == 0) ? ldac0 : (sel == 1) ? ldac1 : ldac2;
  assign done_m = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  assign busy_m = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign ovr_m  = (sel == 0) ? ovr0  : (sel == 1) ? ovr1  : ovr2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor state, written only by the monitor process.
  int unsigned frames_q[$], bits_q[$], cslow_q[$], ldlen_q[$], ldfr_q[$];
  int   sclk_tog = 0, cs_tog = 0, done_cnt = 0, ovr_cnt = 0, sclk_in_ldac = 0;
  logic busy_at_done = 1'b0, busy_before_done = 1'b0;

  initial begin : monitor
    logic        cs_p, sclk_p, ldac_p, busy_p;
    logic [31:0] frm;
    int          bits, cs_low, ldac_len;
    cs_p = 1'b1; sclk_p = 1'b0; ldac_p = 1'b1; busy_p = 1'b0;
    frm = '0; bits = 0; cs_low = 0; ldac_len = 0;
    forever begin
      @(negedge clk);
      if (cs_m !== cs_p) cs_tog++;
      if (sclk_m !== sclk_p) sclk_tog++;
      if (!cs_m && cs_p) begin
        frm = '0; bits = 0; cs_low = 0;
      end
      if (!cs_m) begin
        cs_low++;
        if (sclk_m && !sclk_p) begin
          frm = {frm[30:0], sdin_m};
          bits++;
        end
      end
      if (cs_m && !cs_p) begin
        frames_q.push_back(frm);
        bits_q.push_back(bits);
        cslow_q.push_back(cs_low);
      end
      if (!ldac_m) begin
        if (ldac_p) begin
          ldac_len = 0;
          ldfr_q.push_back(frames_q.size());
        end
        ldac_len++;
        if (sclk_m && !sclk_p) sclk_in_ldac++;
      end
      if (ldac_m && !ldac_p) ldlen_q.push_back(ldac_len);
      if (done_m) begin
        done_cnt++;
        busy_at_done     = busy_m;
        busy_before_done = busy_p;
      end
      if (ovr_m) ovr_cnt++;
      cs_p = cs_m; sclk_p = sclk_m; ldac_p = ldac_m; busy_p = busy_m;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_trig(input int which);
    @(negedge clk);
    case (which)
      0: trig0 = 1'b1;
      1: trig1 = 1'b1;
      default: trig2 = 1'b1;
    endcase
    idle(2);
    trig0 = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_m) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  logic [31:0] exp4 [4];
  logic [31:0] exp8 [8];
  int          bf, bl, bd, bo, bc, bs, bsl, lat;
  logic        seen;

  initial begin
    exp4[0] = 32'h0A5A5; exp4[1] = 32'h11234; exp4[2] = 32'h2BEEF; exp4[3] = 32'h3DEAD;
    exp8[0] = 32'h0A50;  exp8[1] = 32'h1A51;  exp8[2] = 32'h2A52;  exp8[3] = 32'h3A53;
    exp8[4] = 32'h4A54;  exp8[5] = 32'h5A55;  exp8[6] = 32'h6A56;  exp8[7] = 32'h7A57;

    // Reset values
    idle(3);
    chk("rst_cs_n", cs0, 1);
    chk("rst_ldac_n", ldac0, 1);
    chk("rst_rs_n", rs0, 0);
    chk("rst_sclk", sclk0, 0);
    chk("rst_sdin", sdin0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ovr", ovr0, 0);
    chk("rst_msb", {msb0, msb1, msb2}, 3'b111);
    chk("rst_rs_n_all", {rs1, rs2}, 2'b00);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("rs_n_release", {rs0, rs1, rs2}, 3'b111);
    idle(3);

    // Four channels, LDAC per frame, data change and overlapping trigger mid-sequence
    sel = 0;
    data0 = {16'hDEAD, 16'hBEEF, 16'h1234, 16'hA5A5};
    mask0 = 4'hF;
    bf = frames_q.size(); bl = ldlen_q.size(); bd = done_cnt; bo = ovr_cnt;
    @(negedge clk);
    trig0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = busy0;
    end
    chk("busy_rise", seen, 1);
    data0 = '0; mask0 = 4'h1; trig0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = (frames_q.size() == bf + 1) && !cs_m;
    end
    chk("frame2_start", seen, 1);
    pulse_trig(0);
    wait_done(3000, lat, seen);
    chk("done_seen", seen, 1);
    idle(150);
    chk("frame_count", frames_q.size() - bf, 4);
    chk("ldac_count", ldlen_q.size() - bl, 4);
    for (int i = 0; i < 4; i++) begin
      if (frames_q.size() > bf + i) begin
        chk($sformatf("frame%0d", i), frames_q[bf+i], exp4[i]);
        chk($sformatf("bits%0d", i), bits_q[bf+i], 18);
        chk($sformatf("cs_low%0d", i), cslow_q[bf+i], 78);
      end
      if (ldlen_q.size() > bl + i) begin
        chk($sformatf("ldac_w%0d", i), ldlen_q[bl+i], 3);
        chk($sformatf("ldac_after%0d", i), ldfr_q[bl+i] - bf, i + 1);
      end
    end
    chk("done_once", done_cnt - bd, 1);
    chk("ovr_once", ovr_cnt - bo, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("busy_before_done", busy_before_done, 1);

    // Empty mask
    mask0 = 4'h0;
    bc = cs_tog; bs = sclk_tog; bl = ldlen_q.size();
    @(negedge clk);
    trig0 = 1'b1;
    wait_done(20, lat, seen);
    chk("empty_done_seen", seen, 1);
    chk("empty_latency", lat, 3);
    trig0 = 1'b0;
    idle(10);
    chk("empty_cs_tog", cs_tog - bc, 0);
    chk("empty_sclk_tog", sclk_tog - bs, 0);
    chk("empty_ldac", ldlen_q.size() - bl, 0);

    // Single LDAC after the last frame
    sel = 1;
    data1 = {16'hDEAD, 16'hBEEF, 16'h1234, 16'hA5A5};
    mask1 = 4'b1010;
    bf = frames_q.size(); bl = ldlen_q.size(); bsl = sclk_in_ldac;
    pulse_trig(1);
    wait_done(3000, lat, seen);
    chk("m1_done_seen", seen, 1);
    idle(10);
    chk("m1_frames", frames_q.size() - bf, 2);
    if (frames_q.size() >= bf + 2) begin
      chk("m1_frame_a", frames_q[bf], 32'h11234);
      chk("m1_frame_b", frames_q[bf+1], 32'h3DEAD);
    end
    chk("m1_ldac_count", ldlen_q.size() - bl, 1);
    if (ldlen_q.size() > bl) begin
      chk("m1_ldac_w", ldlen_q[bl], 3);
      chk("m1_ldac_after", ldfr_q[bl] - bf, 2);
    end
    chk("m1_sclk_in_ldac", sclk_in_ldac - bsl, 0);

    // Eight channels, 15-bit frames at clk/2
    sel = 2;
    for (int k = 0; k < 8; k++) data2[k*12 +: 12] = 12'(12'hA50 + k);
    mask2 = 8'hFF;
    bf = frames_q.size();
    pulse_trig(2);
    wait_done(3000, lat, seen);
    chk("c8_done_seen", seen, 1);
    idle(5);
    chk("c8_frames", frames_q.size() - bf, 8);
    for (int k = 0; k < 8; k++) begin
      if (frames_q.size() > bf + k) begin
        chk($sformatf("c8_frame%0d", k), frames_q[bf+k], exp8[k]);
        chk($sformatf("c8_bits%0d", k), bits_q[bf+k], 15);
        chk($sformatf("c8_cs_low%0d", k), cslow_q[bf+k], 36);
      end
    end

    // Reset in the middle of a shift
    pulse_trig(2);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = !cs_m && sclk_m;
    end
    chk("c8_in_shift", seen, 1);
    bl = ldlen_q.size(); bd = done_cnt;
    rst2 = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", cs2, 1);
    chk("mid_rst_sclk", sclk2, 0);
    chk("mid_rst_busy", busy2, 0);
    chk("mid_rst_rs_n", rs2, 0);
    chk("mid_rst_ldac_n", ldac2, 1);
    idle(3);
    rst2 = 1'b0;
    idle(60);
    chk("post_rst_ldac", ldlen_q.size() - bl, 0);
    chk("post_rst_done", done_cnt - bd, 0);
    chk("post_rst_cs_n", cs2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
